// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Arbitrates MEM-stage and IF-fetch requests onto one byte-wide
//               synchronous RAM port. Each 1/2/4-byte access is serialised
//               into per-byte RAM cycles, least significant byte first.
// Ports       :
//   clk, rst                         clock (rising edge), async active-high reset
//   mem_rw_in/addr/len/data          MEM request (01 read, 10 write, else none)
//   if_req_in/if_addr_in             IF request (always a 4-byte read)
//   ram_din_in                       RAM read data, valid the cycle after addr
//   ram_addr_out/dout_out/wr_out     RAM byte port
//   busy_out                         high while reading or writing
//   done_out                         one-cycle completion pulse
//   IF_or_MEM_out                    completion owner: 01 MEM, 10 IF
//   data_out                         read result, unused upper bytes zero
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                mem_rw_in,
  input  logic [31:0]               mem_addr_in,
  input  logic [2:0]                mem_len_in,
  input  logic [31:0]               mem_data_in,
  input  logic                      if_req_in,
  input  logic [31:0]               if_addr_in,
  input  logic [7:0]                ram_din_in,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_out,
  output logic [7:0]                ram_dout_out,
  output logic                      ram_wr_out,
  output logic                      busy_out,
  output logic                      done_out,
  output logic [1:0]                IF_or_MEM_out,
  output logic [31:0]               data_out
);

  localparam logic [1:0] c_owner_none = 2'b00;
  localparam logic [1:0] c_owner_mem  = 2'b01;
  localparam logic [1:0] c_owner_if   = 2'b10;

  localparam logic [1:0] c_rw_read  = 2'b01;
  localparam logic [1:0] c_rw_write = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    r_state;
  // Only the low address bits ever reach the RAM, and carries out of them
  // cannot affect them, so the base is kept at RAM width.
  logic [RAM_ADDR_WIDTH-1:0] r_base;
  logic [2:0]                r_len;    // byte count: 1, 2 or 4
  logic [2:0]                r_cyc;    // index of the current cycle, C1 = 1
  logic [23:0]               r_wbuf;   // store bytes not yet driven, byte1 at [7:0]
  logic [1:0]                r_owner;

  logic                      w_mem_rd;
  logic                      w_mem_wr;
  logic [RAM_ADDR_WIDTH-1:0] w_next_addr;

  assign w_mem_rd    = (mem_rw_in == c_rw_read);
  assign w_mem_wr    = (mem_rw_in == c_rw_write);
  // r_cyc equals the byte offset of the address needed in the next cycle.
  assign w_next_addr = r_base + RAM_ADDR_WIDTH'(r_cyc);

  // Upper request-address bits above the RAM width have no effect.
  generate
    if (RAM_ADDR_WIDTH < 32) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^{mem_addr_in[31:RAM_ADDR_WIDTH],
                                  if_addr_in[31:RAM_ADDR_WIDTH]};
    end
  endgenerate

  function automatic logic [2:0] f_len_bytes(input logic [2:0] len);
    case (len)
      3'b001:  f_len_bytes = 3'd1;
      3'b010:  f_len_bytes = 3'd2;
      default: f_len_bytes = 3'd4;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_base        <= '0;
      r_len         <= 3'd0;
      r_cyc         <= 3'd0;
      r_wbuf        <= 24'd0;
      r_owner       <= c_owner_none;
      ram_addr_out  <= '0;
      ram_dout_out  <= 8'd0;
      ram_wr_out    <= 1'b0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      IF_or_MEM_out <= c_owner_none;
      data_out      <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_rd || w_mem_wr) begin
            // MEM has priority over IF.
            r_base       <= mem_addr_in[RAM_ADDR_WIDTH-1:0];
            r_len        <= f_len_bytes(mem_len_in);
            r_owner      <= c_owner_mem;
            r_cyc        <= 3'd1;
            ram_addr_out <= mem_addr_in[RAM_ADDR_WIDTH-1:0];
            busy_out     <= 1'b1;
            if (w_mem_rd) begin
              r_state    <= S_READ;
              data_out   <= 32'd0;
            end else begin
              r_state      <= S_WRITE;
              ram_wr_out   <= 1'b1;
              ram_dout_out <= mem_data_in[7:0];
              r_wbuf       <= mem_data_in[31:8];
            end
          end else if (if_req_in) begin
            r_base       <= if_addr_in[RAM_ADDR_WIDTH-1:0];
            r_len        <= 3'd4;
            r_owner      <= c_owner_if;
            r_cyc        <= 3'd1;
            ram_addr_out <= if_addr_in[RAM_ADDR_WIDTH-1:0];
            busy_out     <= 1'b1;
            data_out     <= 32'd0;
            r_state      <= S_READ;
          end
        end

        S_READ: begin
          // Data for the address issued in cycle Ck arrives in C(k+1), so
          // the byte captured at the end of cycle r_cyc is byte r_cyc-2.
          case (r_cyc)
            3'd2:    data_out[7:0]   <= ram_din_in;
            3'd3:    data_out[15:8]  <= ram_din_in;
            3'd4:    data_out[23:16] <= ram_din_in;
            3'd5:    data_out[31:24] <= ram_din_in;
            default: ;
          endcase
          if (r_cyc < r_len) begin
            ram_addr_out <= w_next_addr;
          end
          if (r_cyc == r_len + 3'd1) begin
            r_state       <= S_DONE;
            r_cyc         <= 3'd0;
            busy_out      <= 1'b0;
            done_out      <= 1'b1;
            IF_or_MEM_out <= r_owner;
          end else begin
            r_cyc <= r_cyc + 3'd1;
          end
        end

        S_WRITE: begin
          if (r_cyc < r_len) begin
            ram_addr_out <= w_next_addr;
            ram_dout_out <= r_wbuf[7:0];
            r_wbuf       <= {8'd0, r_wbuf[23:8]};
            r_cyc        <= r_cyc + 3'd1;
          end else begin
            r_state       <= S_DONE;
            r_cyc         <= 3'd0;
            r_wbuf        <= 24'd0;
            ram_wr_out    <= 1'b0;
            ram_dout_out  <= 8'd0;
            busy_out      <= 1'b0;
            done_out      <= 1'b1;
            IF_or_MEM_out <= r_owner;
          end
        end

        S_DONE: begin
          // Always pass through IDLE so a held request is sampled afresh.
          done_out      <= 1'b0;
          IF_or_MEM_out <= c_owner_none;
          r_state       <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
